instruction_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_fifo.sv | 100 ++++++++++
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   - default address/data widths, reset PC and buffer depth
//   - fetch FSM state encoding
//   - fetch buffer entry layout (PC of the fetched byte plus the byte itself)
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int              FETCH_ADDR_WIDTH = 8;
    localparam int              FETCH_DATA_WIDTH = 8;
    localparam logic [7:0]      FETCH_RESET_PC   = 8'h00;
    localparam int              FETCH_FIFO_DEPTH = 2;

    // BOOT : single idle cycle after reset release
    // RUN  : normal fetch
    // HALTED: fetch stopped until a redirect, buffer keeps draining
    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [FETCH_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Next sequential PC; wraps naturally at 2^width.
    function automatic logic [FETCH_ADDR_WIDTH-1:0] next_pc(
        input logic [FETCH_ADDR_WIDTH-1:0] pc
    );
        return pc + FETCH_ADDR_WIDTH'(1);
    endfunction

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetch entries between the PC/capture logic
// and the decoder.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset, empties the FIFO
//   i_push     in   write i_push_data at the tail (ignored when full unless
//                   a pop happens in the same cycle)
//   i_push_data in  entry to write
//   i_pop      in   remove the head (ignored when empty)
//   i_flush    in   discard every entry; overrides push and pop
//   o_head     out  head entry, all zeros when empty
//   o_full     out  count == DEPTH
//   o_empty    out  count == 0
//   o_count    out  number of stored entries
//
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = FETCH_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  T                 i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output T                 o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is accepted when the head leaves in the same
    // cycle; the freed slot is reused and the count stays put.
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Head reads zero when nothing is buffered so downstream never sees
    // stale data on an invalid cycle.
    assign o_head  = w_empty ? T'('0) : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : fetch_fifo

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage in front of a combinational instruction memory. Owns the PC,
// captures the byte returned for the current PC into a small buffer and
// offers buffered entries to the decoder.
//
// Ports:
//   clk                 in   clock, all state on rising edge
//   rst_n               in   asynchronous active-low reset
//   instruction_address out  PC register, drives the memory address
//   instruction_data    in   memory read data for instruction_address
//   fetch_valid         out  buffer head valid
//   fetch_instr         out  head instruction (0 when not valid)
//   fetch_pc            out  head PC (0 when not valid)
//   fetch_ready         in   decoder accepts the head this cycle
//   redirect_valid      in   flush the buffer and load redirect_target
//   redirect_target     in   new PC
//   halt_req            in   stop fetching until the next redirect
//   halted              out  FSM is in HALTED
//
// Handshake: an entry moves to the decoder on every rising edge where
// fetch_valid and fetch_ready are both high. While fetch_valid is high and
// fetch_ready is low, fetch_instr/fetch_pc are held stable. fetch_valid does
// not depend on fetch_ready.
// -----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = FETCH_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = FETCH_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(FETCH_RESET_PC),
    parameter int                    FIFO_DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] instruction_address,
    input  logic [DATA_WIDTH-1:0] instruction_data,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic [ADDR_WIDTH-1:0] fetch_pc,
    input  logic                  fetch_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  halt_req,
    output logic                  halted
);

    localparam logic [1:0] ST_BOOT   = 2'(BOOT);
    localparam logic [1:0] ST_RUN    = 2'(RUN);
    localparam logic [1:0] ST_HALTED = 2'(HALTED);
    localparam int         CNT_W     = $clog2(FIFO_DEPTH + 1);

    // Entry layout follows the module parameters rather than the package
    // defaults so non-default widths still work.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;

    entry_t                w_push_entry;
    entry_t                w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_pop;
    logic                  w_capture;

    // -------------------------------------------------------------------------
    // Handshake and capture decision
    // -------------------------------------------------------------------------
    assign w_pop = ~w_empty & fetch_ready;

    // Capture only in RUN, never in a halt or redirect cycle, and only when
    // a slot is free or is being freed by a same-cycle pop.
    assign w_capture = (r_state == ST_RUN) & ~halt_req & ~redirect_valid
                     & (~w_full | w_pop);

    assign w_push_entry.pc    = r_pc;
    assign w_push_entry.instr = instruction_data;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            // A redirect during BOOT is applied to PC/FIFO; the state moves to
            // RUN regardless.
            ST_BOOT: w_state_next = ST_RUN;
            ST_RUN: begin
                if (halt_req && !redirect_valid) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (redirect_valid) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Program counter: redirect beats capture; otherwise hold.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_target;
        end else if (w_capture) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Fetch buffer. A redirect flushes it, discarding the head even if the
    // decoder accepted it in the same cycle.
    // -------------------------------------------------------------------------
    fetch_fifo #(
        .T     (entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_capture),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign instruction_address = r_pc;
    assign fetch_valid         = ~w_empty;
    assign fetch_instr         = w_head.instr;
    assign fetch_pc            = w_head.pc;
    assign halted              = (r_state == ST_HALTED);

    // Count is exported by the FIFO for observability; the capture decision
    // only needs full/empty.
    logic w_count_unused;
    assign w_count_unused = ^w_count;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed plus randomized bench for instruction_fetch. A queue-based model
// tracks what the decoder should see each cycle; the memory is an array in
// the bench read combinationally by the DUT address.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    // ------------------------------------------------------------------ clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------ DUT
    logic       rst_n;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       fetch_valid;
    logic [7:0] fetch_instr;
    logic [7:0] fetch_pc;
    logic       fetch_ready;
    logic       redirect_valid;
    logic [7:0] redirect_target;
    logic       halt_req;
    logic       halted;

    logic [7:0] mem [256];
    assign instruction_data = mem[instruction_address];

    instruction_fetch dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .fetch_valid         (fetch_valid),
        .fetch_instr         (fetch_instr),
        .fetch_pc            (fetch_pc),
        .fetch_ready         (fetch_ready),
        .redirect_valid      (redirect_valid),
        .redirect_target     (redirect_target),
        .halt_req            (halt_req),
        .halted              (halted)
    );

    // ------------------------------------------------------------------ model
    // exp_q holds {pc, instr} entries the decoder has yet to receive.
    logic [15:0] exp_q[$];
    logic [7:0]  m_pc;
    bit          m_boot;
    bit          m_halted;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pc     = 8'h00;
        m_boot   = 1'b1;
        m_halted = 1'b0;
    endtask

    // One rising edge of the specification rules, applied to the inputs that
    // were stable before the edge.
    task automatic model_step();
        bit pop;
        pop = (exp_q.size() > 0) && fetch_ready;
        if (redirect_valid) begin
            exp_q.delete();
            m_pc     = redirect_target;
            m_halted = 1'b0;
            m_boot   = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            if (pop) void'(exp_q.pop_front());
        end else if (halt_req) begin
            m_halted = 1'b1;
            if (pop) void'(exp_q.pop_front());
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back({m_pc, mem[m_pc]});
                m_pc = m_pc + 8'd1;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
        chk("valid",   {15'd0, fetch_valid}, {15'd0, exp_q.size() > 0});
        chk("pc",      {8'd0, fetch_pc},     {8'd0, head[15:8]});
        chk("instr",   {8'd0, fetch_instr},  {8'd0, head[7:0]});
        chk("halted",  {15'd0, halted},      {15'd0, m_halted});
        chk("address", {8'd0, instruction_address}, {8'd0, m_pc});
    endtask

    // ------------------------------------------------------------------ driver
    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rdy, input logic redir,
                        input logic [7:0] tgt, input logic halt);
        fetch_ready     = rdy;
        redirect_valid  = redir;
        redirect_target = tgt;
        halt_req        = halt;
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Asynchronous reset between edges, released at a later falling edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_valid",   {15'd0, fetch_valid}, 16'h0000);
        chk("rst_address", {8'd0, instruction_address}, 16'h0000);
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------ stimulus
    initial begin
        logic [7:0] e;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
        fetch_ready     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 8'h00;
        halt_req        = 1'b0;
        rst_n           = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_halted", {15'd0, halted}, 16'h0000);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release: one BOOT cycle, then a stream from RESET_PC.
        step(1, 0, 8'h00, 0);
        chk("boot_valid", {15'd0, fetch_valid}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 0);
            chk("seq_pc",    {8'd0, fetch_pc},    16'(i));
            chk("seq_instr", {8'd0, fetch_instr}, 16'(8'hA0 + i));
        end

        // Back-pressure right after the first valid.
        async_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        repeat (5) step(0, 0, 8'h00, 0);
        chk("stall_address", {8'd0, instruction_address}, 16'h0002);
        chk("stall_pc",      {8'd0, fetch_pc},            16'h0000);
        chk("stall_instr",   {8'd0, fetch_instr},         16'h00A0);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 8'h00, 0);
            chk("release_pc", {8'd0, fetch_pc}, 16'(i));
        end

        // Redirect with a full buffer.
        step(1, 1, 8'h40, 0);
        chk("redir_valid", {15'd0, fetch_valid}, 16'h0000);
        step(1, 0, 8'h00, 0);
        chk("redir_pc",    {8'd0, fetch_pc},    16'h0040);
        chk("redir_instr", {8'd0, fetch_instr}, {8'd0, mem[8'h40]});

        // PC wrap.
        step(1, 1, 8'hFE, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 0);
            e = 8'hFE + 8'(i);
            chk("wrap_pc", {8'd0, fetch_pc}, {8'd0, e});
        end

        // Halt with one buffered entry, then drain and resume via redirect.
        step(0, 0, 8'h00, 1);
        chk("halt_flag",    {15'd0, halted},     16'h0001);
        chk("halt_head_pc", {8'd0, fetch_pc},    16'h0001);
        step(1, 0, 8'h00, 0);
        repeat (3) step(1, 0, 8'h00, 0);
        chk("halt_frozen_pc", {8'd0, instruction_address}, 16'h0002);
        chk("halt_no_valid",  {15'd0, fetch_valid},        16'h0000);
        step(1, 1, 8'h10, 0);
        chk("resume_halted", {15'd0, halted}, 16'h0000);
        step(1, 0, 8'h00, 0);
        chk("resume_pc",    {8'd0, fetch_pc},    16'h0010);
        chk("resume_instr", {8'd0, fetch_instr}, {8'd0, mem[8'h10]});

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(logic'($urandom_range(0, 9) < 7),
                 logic'($urandom_range(0, 19) == 0),
                 8'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset mid-stream and clean restart.
        async_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        chk("restart_pc",    {8'd0, fetch_pc},    16'h0000);
        chk("restart_instr", {8'd0, fetch_instr}, 16'h00A0);
        for (int i = 0; i < 20; i++) begin
            step(logic'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_instruction_fetch
